// File: rtl/dsp_mac_sequencer_if.sv
// rtl/dsp_mac_sequencer_if.sv - job, operand stream, slice and result signals of dsp_mac_sequencer
// r_ovf exists only when DSP_SEQ_OVF_FLAG_EN is defined.
interface dsp_mac_sequencer_if #(
  parameter int LEN_W = 8
);
  logic             start;
  logic [LEN_W-1:0] cfg_len;
  logic             busy;

  logic             s_valid;
  logic             s_ready;
  logic [17:0]      s_a;
  logic [17:0]      s_b;

  logic [17:0]      dsp_a;
  logic [17:0]      dsp_b;
  logic [7:0]       dsp_opmode;
  logic [47:0]      dsp_p_i;
  logic             dsp_cout_i;

  logic             r_valid;
  logic             r_ready;
  logic [47:0]      r_data;
`ifdef DSP_SEQ_OVF_FLAG_EN
  logic             r_ovf;
`endif

  modport master (
    input  start, cfg_len, s_valid, s_a, s_b, dsp_p_i, dsp_cout_i, r_ready,
`ifdef DSP_SEQ_OVF_FLAG_EN
    output r_ovf,
`endif
    output busy, s_ready, dsp_a, dsp_b, dsp_opmode, r_valid, r_data
  );

  modport slave (
    output start, cfg_len, s_valid, s_a, s_b, dsp_p_i, dsp_cout_i, r_ready,
`ifdef DSP_SEQ_OVF_FLAG_EN
    input  r_ovf,
`endif
    input  busy, s_ready, dsp_a, dsp_b, dsp_opmode, r_valid, r_data
  );
endinterface

// File: rtl/dsp_mac_sequencer.sv
// rtl/dsp_mac_sequencer.sv - drives a DSP48A1-style slice as a multiply-accumulator, one 48-bit sum per job
// Optional sticky carry-out flag r_ovf when DSP_SEQ_OVF_FLAG_EN is defined.
module dsp_mac_sequencer #(
  parameter int LEN_W    = 8,
  parameter int PIPE_LAT = 3,
  parameter int OPM_DLY  = 1
) (
  input logic                clk,
  input logic                rst,
  dsp_mac_sequencer_if.master bus
);

  localparam int DRAIN_W = $clog2(PIPE_LAT + 2);

  localparam logic [7:0] OPM_CLEAR = 8'h01;
  localparam logic [7:0] OPM_ACCUM = 8'h09;
  localparam logic [7:0] OPM_HOLD  = 8'h08;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t                      state;
  logic [LEN_W-1:0]            remain;
  logic [DRAIN_W-1:0]          drain_cnt;
  logic                        first;
  logic [OPM_DLY-1:0][7:0]     opm_line;
  logic [7:0]                  opm_pre;
  logic                        xfer;

  assign xfer = bus.s_valid && bus.s_ready;

  // Bubbles must not re-add the product still sitting in the slice M register.
  always_comb begin
    opm_pre = OPM_HOLD;
    if (xfer) begin
      opm_pre = first ? OPM_CLEAR : OPM_ACCUM;
    end
  end

`ifndef DSP_SEQ_OVF_FLAG_EN
  logic unused_cout;
  assign unused_cout = bus.dsp_cout_i;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      remain         <= '0;
      drain_cnt      <= '0;
      first          <= 1'b0;
      opm_line       <= '0;
      bus.dsp_opmode <= '0;
      bus.dsp_a      <= '0;
      bus.dsp_b      <= '0;
      bus.busy       <= 1'b0;
      bus.s_ready    <= 1'b0;
      bus.r_valid    <= 1'b0;
      bus.r_data     <= '0;
`ifdef DSP_SEQ_OVF_FLAG_EN
      bus.r_ovf      <= 1'b0;
`endif
    end else begin
      // Operands are registered once here; the extra opmode stages line it up with the slice M stage.
      opm_line[0] <= opm_pre;
      for (int i = 1; i < OPM_DLY; i++) begin
        opm_line[i] <= opm_line[i-1];
      end
      bus.dsp_opmode <= opm_line[OPM_DLY-1];

      case (state)
        IDLE: begin
          if (bus.start && (bus.cfg_len != '0)) begin
            state       <= ACC;
            remain      <= bus.cfg_len;
            first       <= 1'b1;
            bus.busy    <= 1'b1;
            bus.s_ready <= 1'b1;
`ifdef DSP_SEQ_OVF_FLAG_EN
            bus.r_ovf   <= 1'b0;
`endif
          end
        end

        ACC: begin
`ifdef DSP_SEQ_OVF_FLAG_EN
          bus.r_ovf <= bus.r_ovf | bus.dsp_cout_i;
`endif
          if (xfer) begin
            bus.dsp_a <= bus.s_a;
            bus.dsp_b <= bus.s_b;
            first     <= 1'b0;
            remain    <= remain - LEN_W'(1);
            if (remain == LEN_W'(1)) begin
              state       <= DRAIN;
              bus.s_ready <= 1'b0;
              drain_cnt   <= DRAIN_W'(PIPE_LAT + 1);
            end
          end
        end

        DRAIN: begin
`ifdef DSP_SEQ_OVF_FLAG_EN
          bus.r_ovf <= bus.r_ovf | bus.dsp_cout_i;
`endif
          if (drain_cnt == '0) begin
            state       <= HOLD;
            bus.r_data  <= bus.dsp_p_i;
            bus.r_valid <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - DRAIN_W'(1);
          end
        end

        HOLD: begin
          if (bus.r_valid && bus.r_ready) begin
            state       <= IDLE;
            bus.r_valid <= 1'b0;
            bus.busy    <= 1'b0;
          end
        end

        default: begin
          state       <= IDLE;
          bus.busy    <= 1'b0;
          bus.s_ready <= 1'b0;
          bus.r_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
